// File: rtl/ddr_cmd_pkg.sv
// Shared state encoding, default DRAM timing constants and counter sizing for the command sequencer.
// No logic of its own; zero latency, no backpressure.
package ddr_cmd_pkg;

  localparam int DEF_ROWS    = 128;
  localparam int DEF_COLUMNS = 64;
  localparam int DEF_TRCD    = 2;
  localparam int DEF_TRP     = 2;
  localparam int DEF_TCL     = 2;
  localparam int DEF_TREFI   = 780;
  localparam int DEF_TRFC    = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PRECH = 3'd1;
  localparam state_t ST_ACTV  = 3'd2;
  localparam state_t ST_ISSUE = 3'd3;
  localparam state_t ST_DATA  = 3'd4;
  localparam state_t ST_REFR  = 3'd5;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // One spare bit so the largest "last cycle" value always fits.
  function automatic int cnt_width(input int trcd, input int trp, input int tcl, input int trfc);
    return $clog2(max4(trcd, trp, tcl, trfc)) + 1;
  endfunction

endpackage

// File: rtl/ddr_cmd_sched_if.sv
// Request handshake plus command/data-phase outputs of the DRAM command sequencer.
// Pure wiring; no latency, backpressure carried by req_ready.
interface ddr_cmd_sched_if #(
  parameter int ROW_W = 7,
  parameter int COL_W = 6
);

  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;

  logic             ACT;
  logic             PR;
  logic             RD;
  logic             WR;
  logic             REF;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] column;
  logic             rd_req;
  logic             wr_req;
  logic             done;

  modport master (
    output req_valid, req_wr, req_row, req_col,
    input  req_ready, ACT, PR, RD, WR, REF, row, column, rd_req, wr_req, done
  );

  modport slave (
    input  req_valid, req_wr, req_row, req_col,
    output req_ready, ACT, PR, RD, WR, REF, row, column, rd_req, wr_req, done
  );

endinterface

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh interval counter; raises pending every TREFI non-halted cycles until cleared.
// One-cycle latency from wrap to pending; no backpressure, a wrap while pending is absorbed.
module ddr_refresh_timer #(
  parameter int TREFI = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic halt,
  input  logic clear,
  output logic pending
);

  localparam int            TW   = $clog2(TREFI);
  localparam logic [TW-1:0] WRAP = TW'(TREFI - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;

  // A wrap on the same edge as a clear starts a fresh interval, so set wins.
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (!halt) begin
      if (clear) pending_d = 1'b0;
      if (cnt_q == WRAP) begin
        cnt_d     = '0;
        pending_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/ddr_cmd_sched.sv
// Open-row request-to-command sequencer issuing ACT/PR/RD/WR/REF with tRP/tRCD/tCL/tRFC spacing.
// One request in flight; req_ready low while busy, refreshing or halted; hit RD/WR one cycle after accept.
module ddr_cmd_sched
  import ddr_cmd_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLUMNS = DEF_COLUMNS,
  parameter int TRCD    = DEF_TRCD,
  parameter int TRP     = DEF_TRP,
  parameter int TCL     = DEF_TCL,
  parameter int TREFI   = DEF_TREFI,
  parameter int TRFC    = DEF_TRFC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  ddr_cmd_sched_if.slave   bus
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLUMNS);
  localparam int CNT_W = cnt_width(TRCD, TRP, TCL, TRFC);

  localparam logic [CNT_W-1:0] TRCD_LAST = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] TCL_LAST  = CNT_W'(TCL - 1);
  localparam logic [CNT_W-1:0] TRFC_LAST = CNT_W'(TRFC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             wr_q, wr_d;
  logic             open_q, open_d;
  logic             ref_svc_q, ref_svc_d;

  logic             ref_pending;
  logic             ref_clear;
  logic             req_ready;
  logic             accept;

  ddr_refresh_timer #(
    .TREFI (TREFI)
  ) u_refresh_timer (
    .clk     (clk),
    .rst     (rst),
    .halt    (halt),
    .clear   (ref_clear),
    .pending (ref_pending)
  );

  assign req_ready = rst && (state_q == ST_IDLE) && !ref_pending && !halt;
  assign accept    = bus.req_valid && req_ready;

  // cnt_q is zero on the first cycle of every state; strobes key off that, so a
  // halted entry cycle simply defers the strobe to the next live cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    wr_d      = wr_q;
    open_d    = open_q;
    ref_svc_d = ref_svc_q;
    ref_clear = 1'b0;
    if (!halt) begin
      cnt_d = cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (ref_pending) begin
            ref_svc_d = 1'b1;
            if (open_q) begin
              state_d = ST_PRECH;
            end else begin
              state_d = ST_REFR;
              row_d   = '0;
              col_d   = '0;
            end
          end else if (accept) begin
            row_d     = bus.req_row;
            col_d     = bus.req_col;
            wr_d      = bus.req_wr;
            ref_svc_d = 1'b0;
            if (!open_q)                    state_d = ST_ACTV;
            else if (row_q == bus.req_row)  state_d = ST_ISSUE;
            else                            state_d = ST_PRECH;
          end
        end
        ST_PRECH: begin
          open_d = 1'b0;
          if (cnt_q == TRP_LAST) begin
            cnt_d = '0;
            if (ref_svc_q) begin
              state_d = ST_REFR;
              row_d   = '0;
              col_d   = '0;
            end else begin
              state_d = ST_ACTV;
            end
          end
        end
        ST_ACTV: begin
          if (cnt_q == TRCD_LAST) begin
            cnt_d   = '0;
            open_d  = 1'b1;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (cnt_q == TCL_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_REFR: begin
          if (cnt_q == TRFC_LAST) begin
            cnt_d     = '0;
            open_d    = 1'b0;
            ref_svc_d = 1'b0;
            ref_clear = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wr_q      <= 1'b0;
      open_q    <= 1'b0;
      ref_svc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_q      <= wr_d;
      open_q    <= open_d;
      ref_svc_q <= ref_svc_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.ACT       = !halt && (state_q == ST_ACTV)  && (cnt_q == '0);
  assign bus.PR        = !halt && (state_q == ST_PRECH) && (cnt_q == '0);
  assign bus.REF       = !halt && (state_q == ST_REFR)  && (cnt_q == '0);
  assign bus.RD        = !halt && (state_q == ST_ISSUE) && !wr_q;
  assign bus.WR        = !halt && (state_q == ST_ISSUE) &&  wr_q;
  assign bus.rd_req    = !halt && (state_q == ST_DATA)  && !wr_q;
  assign bus.wr_req    = !halt && (state_q == ST_DATA)  &&  wr_q;
  assign bus.done      = !halt && (state_q == ST_DATA)  && (cnt_q == TCL_LAST);
  assign bus.row       = row_q;
  assign bus.column    = col_q;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Directed scoreboard bench for ddr_cmd_sched: expected command events queued at accept, popped by a monitor.
module tb_ddr_cmd_sched;

  localparam int TRCD  = 2;
  localparam int TRP   = 2;
  localparam int TCL   = 2;
  localparam int TREFI = 64;
  localparam int TRFC  = 4;

  localparam int E_ACT = 0, E_PR = 1, E_RD = 2, E_WR = 3, E_REF = 4;
  localparam int E_RDQ = 5, E_WRQ = 6, E_DONE = 7, E_RDY = 8;
  localparam int P_HIT = 0, P_CLOSED = 1, P_MISS = 2;

  typedef struct {
    int         kind;
    int         cyc;
    bit         chk;
    logic [6:0] row;
    logic [5:0] col;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic halt;
  int   cyc = 0;
  int   r0 = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_rdy = 1'b0;
  exp_t exp_q[$];

  ddr_cmd_sched_if #(.ROW_W(7), .COL_W(6)) bus();

  ddr_cmd_sched #(
    .ROWS(128), .COLUMNS(64), .TRCD(TRCD), .TRP(TRP), .TCL(TCL), .TREFI(TREFI), .TRFC(TRFC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .halt (halt),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(input int k);
    case (k)
      E_ACT:  return "ACT";
      E_PR:   return "PR";
      E_RD:   return "RD";
      E_WR:   return "WR";
      E_REF:  return "REF";
      E_RDQ:  return "rd_req";
      E_WRQ:  return "wr_req";
      E_DONE: return "done";
      E_RDY:  return "ready_rise";
      default: return "?";
    endcase
  endfunction

  task automatic push_ev(input int k, input int c, input bit chk, input logic [6:0] r, input logic [5:0] cl);
    exp_t e;
    e.kind = k; e.cyc = c; e.chk = chk; e.row = r; e.col = cl;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [6:0] r, input logic [5:0] cl);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got %s at cycle %0d, required no event", ev_name(k), cyc - r0);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || (e.chk && (e.row != r || e.col != cl))) begin
        n_fail++;
        $display("FAIL event: got %s cyc %0d row %0d col %0d, required %s cyc %0d row %0d col %0d",
                 ev_name(k), cyc - r0, r, cl, ev_name(e.kind), e.cyc - r0, e.row, e.col);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {23'd0, bus.ACT, bus.PR, bus.RD, bus.WR, bus.REF, bus.rd_req, bus.wr_req, bus.done, bus.req_ready};
  endfunction

  // Monitor: every output event in a cycle is matched against the queue in fixed order.
  always @(negedge clk) begin
    if (bus.ACT === 1'b1)    check_ev(E_ACT, bus.row, bus.column);
    if (bus.PR === 1'b1)     check_ev(E_PR, bus.row, bus.column);
    if (bus.RD === 1'b1)     check_ev(E_RD, bus.row, bus.column);
    if (bus.WR === 1'b1)     check_ev(E_WR, bus.row, bus.column);
    if (bus.REF === 1'b1)    check_ev(E_REF, bus.row, bus.column);
    if (bus.rd_req === 1'b1) check_ev(E_RDQ, bus.row, bus.column);
    if (bus.wr_req === 1'b1) check_ev(E_WRQ, bus.row, bus.column);
    if (bus.done === 1'b1)   check_ev(E_DONE, bus.row, bus.column);
    if (bus.req_ready === 1'b1 && prev_rdy !== 1'b1) check_ev(E_RDY, bus.row, bus.column);
    prev_rdy = bus.req_ready;
  end

  task automatic push_seq(input int path, input int hdly, input logic w,
                          input logic [6:0] r, input logic [5:0] cl, input int t);
    int b;
    b = t + 1;
    if (path == P_MISS) begin
      push_ev(E_PR, b, 1'b0, 7'd0, 6'd0);
      b += TRP;
    end
    if (path != P_HIT) begin
      push_ev(E_ACT, b, 1'b1, r, cl);
      b += TRCD + hdly;
    end
    push_ev(w ? E_WR : E_RD, b, 1'b1, r, cl);
    for (int i = 1; i <= TCL; i++) begin
      push_ev(w ? E_WRQ : E_RDQ, b + i, 1'b0, 7'd0, 6'd0);
      if (i == TCL) push_ev(E_DONE, b + i, 1'b0, 7'd0, 6'd0);
    end
    push_ev(E_RDY, b + TCL + 1, 1'b0, 7'd0, 6'd0);
  endtask

  task automatic do_req(input logic w, input logic [6:0] r, input logic [5:0] cl,
                        input int path, input int hdly, input bit full, output int t);
    bit got;
    got = 1'b0;
    t = cyc;
    bus.req_valid = 1'b1;
    bus.req_wr    = w;
    bus.req_row   = r;
    bus.req_col   = cl;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        got = 1'b1;
        t = cyc;
        if (full) push_seq(path, hdly, w, r, cl, t);
      end
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL accept_timeout: got no accept in 300 cycles, required accept");
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b0;
    halt = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_row = '0;
    bus.req_col = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), 32'd0);
    chk("reset_row", {25'd0, bus.row}, 32'd0);
    chk("reset_col", {26'd0, bus.column}, 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    r0 = cyc;
    push_ev(E_RDY, r0, 1'b0, 7'd0, 6'd0);

    // Closed row read, then hit read, then miss write.
    do_req(1'b0, 7'd5, 6'd3, P_CLOSED, 0, 1'b1, t);
    chk("first_accept_cycle", t - r0, 0);
    do_req(1'b0, 7'd5, 6'd9, P_HIT, 0, 1'b1, t);
    do_req(1'b1, 7'd7, 6'd1, P_MISS, 0, 1'b1, t);

    // First refresh with row 7 open: pending visible at cycle 64.
    push_ev(E_PR,  r0 + 65, 1'b0, 7'd0, 6'd0);
    push_ev(E_REF, r0 + 67, 1'b0, 7'd0, 6'd0);
    push_ev(E_RDY, r0 + 71, 1'b0, 7'd0, 6'd0);
    wait_cyc(r0 + 63);
    @(negedge clk);
    chk("ready_before_pending", {31'd0, bus.req_ready}, 32'd1);
    wait_cyc(r0 + 64);
    @(negedge clk);
    chk("ready_at_pending", {31'd0, bus.req_ready}, 32'd0);

    // Refresh closed the row, so this read opens it again.
    do_req(1'b0, 7'd5, 6'd2, P_CLOSED, 0, 1'b1, t);
    chk("accept_after_refresh", t - r0, 71);

    // Miss read with halt held three cycles in the ACT wait.
    do_req(1'b0, 7'd9, 6'd4, P_MISS, 3, 1'b1, t);
    wait_cyc(t + 4);
    halt = 1'b1;
    wait_cyc(t + 7);
    halt = 1'b0;

    // Second refresh lands three cycles late because of the halt.
    push_ev(E_PR,  r0 + 132, 1'b0, 7'd0, 6'd0);
    push_ev(E_REF, r0 + 134, 1'b0, 7'd0, 6'd0);
    push_ev(E_RDY, r0 + 138, 1'b0, 7'd0, 6'd0);
    wait_cyc(r0 + 130);
    @(negedge clk);
    chk("ready_before_pending2", {31'd0, bus.req_ready}, 32'd1);
    wait_cyc(r0 + 131);
    @(negedge clk);
    chk("ready_at_pending2", {31'd0, bus.req_ready}, 32'd0);

    // Write aborted by reset during its first data cycle.
    do_req(1'b1, 7'd9, 6'd5, P_CLOSED, 0, 1'b0, t);
    chk("accept_after_refresh2", t - r0, 138);
    push_ev(E_ACT, t + 1, 1'b1, 7'd9, 6'd5);
    push_ev(E_WR,  t + 3, 1'b1, 7'd9, 6'd5);
    push_ev(E_WRQ, t + 4, 1'b0, 7'd0, 6'd0);
    push_ev(E_RDY, t + 6, 1'b0, 7'd0, 6'd0);
    wait_cyc(t + 4);
    rst = 1'b0;
    wait_cyc(t + 5);
    @(negedge clk);
    chk("midreset_outputs", out_vec(), 32'd0);
    chk("midreset_row", {25'd0, bus.row}, 32'd0);
    chk("midreset_col", {26'd0, bus.column}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset closed the row: ACT expected again.
    do_req(1'b0, 7'd9, 6'd5, P_CLOSED, 0, 1'b1, t);
    wait_cyc(t + 10);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_sched.md
# ddr_cmd_sched

Request-to-command sequencer feeding the DRAM timing/array wrapper. It accepts one read or write request at a time over a valid/ready handshake and issues ACT/PR/RD/WR/REF strobes with enforced tRP/tRCD/tCL spacing. It drives row/column and the rd_req/wr_req data-phase qualifiers, and uses an open-row policy. A periodic refresh timer inserts REF commands between requests.

## Interface
Parameters:
- ROWS, 128, rows per bank; row width = $clog2(ROWS)
- COLUMNS, 64, columns per row; column width = $clog2(COLUMNS)
- TRCD, 2, cycles from ACT to RD/WR (≥1)
- TRP, 2, cycles from PR to ACT/REF (≥1)
- TCL, 2, data-phase length in cycles (≥1)
- TREFI, 780, refresh interval in non-halted cycles (≥2)
- TRFC, 8, cycles from REF until the next command (≥1)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-low
- halt  in  1  emulation stall; freezes all state
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_wr  in  1  1 = write, 0 = read
- req_row  in  $clog2(ROWS)  target row
- req_col  in  $clog2(COLUMNS)  target column
- ACT, PR, RD, WR, REF  out  1 each  one-cycle command strobes
- row  out  $clog2(ROWS)  row of current command
- column  out  $clog2(COLUMNS)  column of current command
- rd_req, wr_req  out  1  data-phase qualifiers
- done  out  1  pulse on the last data-phase cycle

## Operation
- States: IDLE, PRECH, ACTV, ISSUE, DATA, REFR.
- req_ready = rst && state==IDLE && !ref_pending && !halt. The request is captured on the accepting edge. row/column update only on accept or refresh and hold otherwise.
- Routing from IDLE on accept:
  - row open and equal to req_row → ISSUE
  - row open and different → PRECH
  - row closed → ACTV
- PRECH: PR pulses on entry; waits TRP cycles. Then → ACTV, or → REFR if refresh is being serviced. Row becomes closed.
- ACTV: ACT pulses on entry with the new row; waits TRCD cycles → ISSUE. Row becomes open.
- ISSUE: RD or WR pulses for one cycle → DATA.
- DATA: rd_req or wr_req held for TCL cycles. done pulses on the final cycle → IDLE.
- Refresh timer:
  - Counts non-halted cycles and sets ref_pending at count TREFI-1, then reloads 0.
  - While pending, ready is low. From IDLE: → PRECH if a row is open, else → REFR.
  - REFR: REF pulses on entry; waits TRFC cycles. Then clears pending → IDLE, row closed.
  - A timer wrap while already pending keeps pending at 1 (no queuing).
- Simultaneous accept and pending-set on the same edge: the request is accepted. Refresh is serviced after that request's done.
- Halt: FSM, wait counters and refresh timer all freeze. Command strobes, done, rd_req and wr_req are ANDed with !halt, so each strobe is delivered exactly once, in a non-halted cycle.

## Timing
- Reset (rst low at an edge): state IDLE, row closed, counters 0, ref_pending 0, row/column 0. All strobes, rd_req, wr_req, done and req_ready are 0. Reset mid-sequence aborts immediately with no trailing strobe.
- Accept at cycle T, no halt:
  - Hit: RD/WR at T+1, data T+2..T+1+TCL, done at T+1+TCL, ready at T+2+TCL.
  - Closed: ACT T+1, RD/WR T+1+TRCD, done T+1+TRCD+TCL.
  - Miss: PR T+1, ACT T+1+TRP, RD/WR T+1+TRP+TRCD.
- Refresh entered from IDLE at cycle t with row closed: REF at t+1, IDLE at t+1+TRFC.
- Halt cycles extend every interval above 1:1.

## Structure
- Package ddr_cmd_pkg holds the state enum and the default timing constants. Counter width = $clog2 of the largest of TRCD, TRP, TCL, TRFC, plus 1.
- Sub-module ddr_refresh_timer holds the TREFI counter and pending flag. Its inputs are clk, rst, halt, clear; its output is pending.

## Test plan
Bench parameters: TRCD=2, TRP=2, TCL=2, TREFI=64, TRFC=4.
- Read row 5 col 3 accepted at T=0 after reset → ACT@1 row=5; RD@3 col=3; rd_req@4,5; done@5; ready@6.
- Second read row 5 col 9 → RD@T+1, no ACT/PR, done@T+3.
- Write row 7 while row 5 open → PR@T+1, ACT@T+3 row=7, WR@T+5, wr_req@T+6,T+7.
- Refresh with row open, idle → ready low at pending; PR, REF 2 cycles later, ready high 4 cycles after REF; row closed, so the next request issues ACT.
- halt held 3 cycles during ACTV wait → RD delayed exactly 3 cycles; no duplicate ACT; refresh count frozen.
- rst low during DATA → next cycle all outputs 0, state IDLE; no done pulse.
